// File: rtl/logic_gate_unit_pkg.sv
// Shared types for logic_gate_unit: op codes, buffer occupancy states, buffer depth.
package logic_gate_unit_pkg;

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NAND   = 3'd2,
    OP_NOR    = 3'd3,
    OP_XOR    = 3'd4,
    OP_XNOR   = 3'd5,
    OP_NOT_A  = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int unsigned DEPTH = 2;

endpackage

// File: rtl/logic_gate_unit_gate_cell.sv
// gate_cell: 1-bit logic cell; every op and the 8:1 op select are built from 2-input NANDs.
module gate_cell (
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       z
);

  wire w_na, w_nb, w_nand, w_and, w_or, w_nor;
  wire w_xa, w_xb, w_xor, w_xnor, w_pass;
  wire [2:0] w_ns;
  wire [7:0] w_l0;
  wire [3:0] w_l1;
  wire [1:0] w_l2;
  wire       w_l3;

  nand u_na   (w_na,   a,      a);
  nand u_nb   (w_nb,   b,      b);
  nand u_nand (w_nand, a,      b);
  nand u_and  (w_and,  w_nand, w_nand);
  nand u_or   (w_or,   w_na,   w_nb);
  nand u_nor  (w_nor,  w_or,   w_or);
  nand u_xa   (w_xa,   a,      w_nand);
  nand u_xb   (w_xb,   b,      w_nand);
  nand u_xor  (w_xor,  w_xa,   w_xb);
  nand u_xnor (w_xnor, w_xor,  w_xor);
  nand u_pass (w_pass, w_na,   w_na);

  assign w_l0 = {w_pass, w_na, w_xnor, w_xor, w_nor, w_nand, w_or, w_and};

  for (genvar s = 0; s < 3; s++) begin : g_sel_inv
    nand u_inv (w_ns[s], op[s], op[s]);
  end

  // Binary mux tree, one level per op bit: out = nand(nand(hi, s), nand(lo, ~s)).
  for (genvar j = 0; j < 4; j++) begin : g_lvl1
    wire w_hi, w_lo;
    nand u_hi  (w_hi,    w_l0[2*j+1], op[0]);
    nand u_lo  (w_lo,    w_l0[2*j],   w_ns[0]);
    nand u_out (w_l1[j], w_hi,        w_lo);
  end

  for (genvar k = 0; k < 2; k++) begin : g_lvl2
    wire w_hi, w_lo;
    nand u_hi  (w_hi,    w_l1[2*k+1], op[1]);
    nand u_lo  (w_lo,    w_l1[2*k],   w_ns[1]);
    nand u_out (w_l2[k], w_hi,        w_lo);
  end

  wire w_hi3, w_lo3;
  nand u_hi3  (w_hi3, w_l2[1], op[2]);
  nand u_lo3  (w_lo3, w_l2[0], w_ns[2]);
  nand u_out3 (w_l3,  w_hi3,   w_lo3);

  assign z = w_l3;

endmodule

// File: rtl/logic_gate_unit.sv
// logic_gate_unit: registered bitwise logic unit with a 2-entry valid/ready output buffer.
// Define LOGIC_GATE_UNIT_PARITY_EN to store and drive even parity of each result on out_par.
module logic_gate_unit
  import logic_gate_unit_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned OPW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  input  logic [OPW-1:0] in_op,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_z,
  output logic [OPW-1:0] out_op,
  output logic           out_par
);

  logic [W-1:0]   w_z;
  logic           w_acc;
  logic           w_ret;
  state_e         r_state;
  state_e         w_state_d;
  logic           r_in_ready;
  logic           r_wr_ptr;
  logic           r_rd_ptr;
  logic [W-1:0]   r_z_mem  [DEPTH];
  logic [OPW-1:0] r_op_mem [DEPTH];

  for (genvar i = 0; i < int'(W); i++) begin : g_cell
    gate_cell u_cell (
      .a  (in_a[i]),
      .b  (in_b[i]),
      .op (in_op),
      .z  (w_z[i])
    );
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign w_acc     = in_valid && r_in_ready;
  assign w_ret     = out_valid && out_ready;

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_acc) w_state_d = ST_ONE;
      ST_ONE: begin
        if (w_acc && !w_ret)      w_state_d = ST_FULL;
        else if (!w_acc && w_ret) w_state_d = ST_EMPTY;
      end
      ST_FULL:  if (w_ret) w_state_d = ST_ONE;
      default:  w_state_d = ST_EMPTY;
    endcase
  end

  // in_ready is registered from the next occupancy, so it already reflects this edge's traffic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_z_mem[i]  <= '0;
        r_op_mem[i] <= '0;
      end
    end else begin
      r_state    <= w_state_d;
      r_in_ready <= (w_state_d != ST_FULL);
      if (w_acc) begin
        r_z_mem[r_wr_ptr]  <= w_z;
        r_op_mem[r_wr_ptr] <= in_op;
        r_wr_ptr           <= ~r_wr_ptr;
      end
      if (w_ret) r_rd_ptr <= ~r_rd_ptr;
    end
  end

  assign out_z  = r_z_mem[r_rd_ptr];
  assign out_op = r_op_mem[r_rd_ptr];

`ifdef LOGIC_GATE_UNIT_PARITY_EN
  logic r_par_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_par_mem[i] <= 1'b0;
    end else if (w_acc) begin
      r_par_mem[r_wr_ptr] <= ^w_z;
    end
  end

  assign out_par = r_par_mem[r_rd_ptr];
`else
  assign out_par = 1'b0;
`endif

endmodule
